seg7_scan_decoder: RTL

//  Inverse of the BCD->7-seg path: samples a time-multiplexed 7-segment bus
//  (segments + one-hot digit select), filters each digit for stability, decodes

---
 rtl/seg7_pkg.sv | 39 +++
 rtl/seg7_digit_filter.sv | 66 ++++++
 rtl/seg7_scan_decoder.sv | 102 ++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the scanned 7-segment readback path: segment codes,
// the pattern-to-BCD decode and the output-stage state type.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;

  localparam logic [3:0] BCD_INVALID = 4'hF;

  typedef enum logic {EMPTY, FULL} out_state_t;

  // Returns {err, bcd}; anything outside the ten legal codes is flagged.
  function automatic logic [4:0] seg7_to_bcd(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      SEG_0:   res = {1'b0, 4'd0};
      SEG_1:   res = {1'b0, 4'd1};
      SEG_2:   res = {1'b0, 4'd2};
      SEG_3:   res = {1'b0, 4'd3};
      SEG_4:   res = {1'b0, 4'd4};
      SEG_5:   res = {1'b0, 4'd5};
      SEG_6:   res = {1'b0, 4'd6};
      SEG_7:   res = {1'b0, 4'd7};
      SEG_8:   res = {1'b0, 4'd8};
      SEG_9:   res = {1'b0, 4'd9};
      default: res = {1'b1, BCD_INVALID};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/seg7_digit_filter.sv
// Per-digit stability filter: counts consecutive identical samples and reports
// an accept pulse (with the decoded value) on the sample that reaches STABLE_CNT.
module seg7_digit_filter
  import seg7_pkg::*;
#(
  parameter int STABLE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample,
  input  logic [6:0] seg_in,
  output logic       accept,
  output logic [3:0] bcd_next,
  output logic       err_next
);

  localparam int CNT_W = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [6:0]       last_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       bcd_reg;
  logic             err_reg;
  logic             same;
  logic [4:0]       dec;

  assign same = (seg_in == last_reg);
  assign dec  = seg7_to_bcd(seg_in);

  // bcd_next/err_next expose the post-edge value so the top can capture a
  // frame on the same edge the final digit is accepted.
  always_comb begin
    cnt_next = cnt_reg;
    accept   = 1'b0;
    bcd_next = bcd_reg;
    err_next = err_reg;
    if (sample) begin
      if (same)
        cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_ONE;
      else
        cnt_next = CNT_ONE;
      // A fresh pattern reaching the threshold counts as a transition even
      // when the counter was already saturated (matters for STABLE_CNT=1).
      accept = (cnt_next == CNT_MAX) && (!same || cnt_reg != CNT_MAX);
      if (accept)
        {err_next, bcd_next} = dec;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_reg <= '0;
      cnt_reg  <= '0;
      bcd_reg  <= '0;
      err_reg  <= 1'b0;
    end else begin
      if (sample && !same)
        last_reg <= seg_in;
      cnt_reg <= cnt_next;
      bcd_reg <= bcd_next;
      err_reg <= err_next;
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Readback of a time-multiplexed 7-segment bus: filters each digit, collects a
// complete frame and hands it out on a valid/ready interface.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int STABLE_CNT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sample_en,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    sel_err,
  output logic                    overrun
);

  localparam logic [NUM_DIGITS-1:0] SEL_ONE = NUM_DIGITS'(1);

  out_state_t                state_reg, state_next;
  logic [NUM_DIGITS-1:0]     seen_reg, seen_all;
  logic [NUM_DIGITS-1:0]     accept_vec, err_next_vec;
  logic [4*NUM_DIGITS-1:0]   bcd_next_vec;
  logic [4*NUM_DIGITS-1:0]   bcd_out_reg;
  logic [NUM_DIGITS-1:0]     digit_err_reg;
  logic                      sel_err_reg, overrun_reg, overrun_next;
  logic                      one_hot, complete, load;

  assign one_hot = (dig_sel != '0) && ((dig_sel & (dig_sel - SEL_ONE)) == '0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      seg7_digit_filter #(.STABLE_CNT(STABLE_CNT)) u_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .sample   (sample_en && one_hot && dig_sel[gi]),
        .seg_in   (seg_in),
        .accept   (accept_vec[gi]),
        .bcd_next (bcd_next_vec[4*gi +: 4]),
        .err_next (err_next_vec[gi])
      );
    end
  endgenerate

  assign seen_all = seen_reg | accept_vec;
  assign complete = &seen_all;

  always_comb begin
    state_next   = state_reg;
    load         = 1'b0;
    overrun_next = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (complete) begin
          load       = 1'b1;
          state_next = FULL;
        end
      end
      FULL: begin
        if (frame_ready) begin
          if (complete) load = 1'b1;
          else          state_next = EMPTY;
        end else if (complete) begin
          overrun_next = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= EMPTY;
      seen_reg      <= '0;
      bcd_out_reg   <= '0;
      digit_err_reg <= '0;
      sel_err_reg   <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      seen_reg    <= complete ? '0 : seen_all;
      sel_err_reg <= sample_en && !one_hot;
      overrun_reg <= overrun_next;
      if (load) begin
        bcd_out_reg   <= bcd_next_vec;
        digit_err_reg <= err_next_vec;
      end
    end
  end

  assign frame_valid = (state_reg == FULL);
  assign bcd_out     = bcd_out_reg;
  assign digit_err   = digit_err_reg;
  assign sel_err     = sel_err_reg;
  assign overrun     = overrun_reg;

endmodule
